// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD down-timer: FSM state encoding and BCD digit limits.
// No logic of its own; no latency and no backpressure apply.
package bcd_pkg;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of a borrow-chained decrementer. Combinational, so zero latency.
// No backpressure: borrow_out is high only when this digit wraps 0 -> 9.
module bcd_digit_dec
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digit_in,
    input  logic             borrow_in,
    output logic [BCD_W-1:0] digit_out,
    output logic             borrow_out
);

    logic at_zero;

    assign at_zero    = (digit_in == '0);
    assign borrow_out = borrow_in & at_zero;

    always_comb begin
        digit_out = digit_in;
        if (borrow_in) begin
            digit_out = at_zero ? BCD_MAX : (digit_in - 4'd1);
        end
    end

endmodule

// File: rtl/bcd_down_timer.sv
// BCD down-counter with IDLE/RUN/PAUSED control; outputs registered, one-cycle latency from inputs.
// No backpressure: strobes are taken in priority load > pause > start > tick; define BCD_DOWN_TIMER_AUTO_RELOAD_EN to reload on expiry.
module bcd_down_timer
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        load,
    input  logic [4*NUM_DIGITS-1:0]     load_val,
    input  logic                        start,
    input  logic                        pause,
    input  logic                        tick,
    output logic [4*NUM_DIGITS-1:0]     q,
    output logic                        running,
    output logic                        done,
    output logic                        load_err
);

    localparam int W = BCD_W * NUM_DIGITS;

    state_e         state_q, state_d;
    logic [W-1:0]   q_q, q_d;
    logic           running_q, running_d;
    logic           done_q, done_d;
    logic           load_err_q, load_err_d;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
    logic [W-1:0]   reload_q, reload_d;
`endif

    logic [W-1:0]        q_dec;
    logic [NUM_DIGITS:0] borrow;
    logic                q_is_zero;
    logic                q_is_one;
    logic                load_ok;

    // Digit 0 always decrements; the final borrow out means the whole count is zero.
    assign borrow[0] = 1'b1;
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        bcd_digit_dec u_dig (
            .digit_in   (q_q[i*BCD_W +: BCD_W]),
            .borrow_in  (borrow[i]),
            .digit_out  (q_dec[i*BCD_W +: BCD_W]),
            .borrow_out (borrow[i+1])
        );
    end

    assign q_is_zero = borrow[NUM_DIGITS];
    assign q_is_one  = (q_q == W'(1));

    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (load_val[i*BCD_W +: BCD_W] > BCD_MAX) begin
                load_ok = 1'b0;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        q_d        = q_q;
        done_d     = 1'b0;
        load_err_d = 1'b0;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
        reload_d   = reload_q;
`endif
        if (load) begin
            if (load_ok) begin
                q_d     = load_val;
                state_d = ST_IDLE;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
                reload_d = load_val;
`endif
            end else begin
                load_err_d = 1'b1;
            end
        end else if (pause) begin
            if (state_q == ST_RUN) begin
                state_d = ST_PAUSED;
            end
        end else if (start) begin
            if ((state_q != ST_RUN) && !q_is_zero) begin
                state_d = ST_RUN;
            end
        end else if (tick && (state_q == ST_RUN)) begin
            if (q_is_one) begin
                done_d = 1'b1;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
                q_d     = reload_q;
`else
                q_d     = '0;
                state_d = ST_IDLE;
`endif
            end else begin
                q_d = q_dec;
            end
        end
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            q_q        <= '0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
            reload_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            q_q        <= q_d;
            running_q  <= running_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
            reload_q   <= reload_d;
`endif
        end
    end

    assign q        = q_q;
    assign running  = running_q;
    assign done     = done_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Bench for bcd_down_timer: directed scenarios plus randomized strobes against an integer-count reference model.
// Honours BCD_DOWN_TIMER_AUTO_RELOAD_EN the same way the design does.
module tb_bcd_down_timer;

    localparam int ND = 4;
    localparam int W  = 4 * ND;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         load;
    logic [W-1:0] load_val;
    logic         start;
    logic         pause;
    logic         tick;
    logic [W-1:0] q;
    logic         running;
    logic         done;
    logic         load_err;

    bcd_down_timer #(.NUM_DIGITS(ND)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .tick     (tick),
        .q        (q),
        .running  (running),
        .done     (done),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: count kept as a plain integer, mode 0 idle / 1 run / 2 paused.
    int m_cnt    = 0;
    int m_reload = 0;
    int m_mode   = 0;
    bit m_done   = 0;
    bit m_err    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int           x;
        r = '0;
        x = v;
        for (int i = 0; i < ND; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit bcd_ok(input logic [W-1:0] v);
        for (int i = 0; i < ND; i++) begin
            if (v[i*4 +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int from_bcd(input logic [W-1:0] v);
        int r;
        r = 0;
        for (int i = ND - 1; i >= 0; i--) begin
            r = r * 10 + int'(v[i*4 +: 4]);
        end
        return r;
    endfunction

    task automatic cycle(input bit rn, input bit ld, input logic [W-1:0] lv,
                         input bit pa, input bit sa, input bit tk);
        reset_n  = rn;
        load     = ld;
        load_val = lv;
        pause    = pa;
        start    = sa;
        tick     = tk;
        @(posedge clk);
        #1;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (!rn) begin
            m_cnt    = 0;
            m_reload = 0;
            m_mode   = 0;
        end else if (ld) begin
            if (bcd_ok(lv)) begin
                m_cnt    = from_bcd(lv);
                m_reload = m_cnt;
                m_mode   = 0;
            end else begin
                m_err = 1'b1;
            end
        end else if (pa) begin
            if (m_mode == 1) m_mode = 2;
        end else if (sa) begin
            if (m_mode != 1 && m_cnt != 0) m_mode = 1;
        end else if (tk && m_mode == 1) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                m_done = 1'b1;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
                m_cnt = m_reload;
`else
                m_mode = 0;
`endif
            end
        end
        check("q", q, to_bcd(m_cnt));
        check("running", running, (m_mode == 1));
        check("done", done, m_done);
        check("load_err", load_err, m_err);
    endtask

    task automatic do_idle();           cycle(1, 0, '0, 0, 0, 0); endtask
    task automatic do_load(input logic [W-1:0] v); cycle(1, 1, v, 0, 0, 0); endtask
    task automatic do_start();          cycle(1, 0, '0, 0, 1, 0); endtask
    task automatic do_tick();           cycle(1, 0, '0, 0, 0, 1); endtask
    task automatic do_reset();          cycle(0, 0, '0, 0, 0, 0); endtask

    initial begin
        int done_cnt;

        do_reset();
        do_reset();
        check("rst_q", q, 16'h0000);
        check("rst_running", running, 1'b0);

        // Three-tick countdown to expiry.
        do_load(16'h0003);
        do_start();
        do_tick();
        check("c3_q1", q, 16'h0002);
        do_tick();
        check("c3_q2", q, 16'h0001);
        do_tick();
        check("c3_done", done, 1'b1);
`ifndef BCD_DOWN_TIMER_AUTO_RELOAD_EN
        check("c3_q3", q, 16'h0000);
`endif
        do_idle();
        check("c3_done_once", done, 1'b0);
`ifndef BCD_DOWN_TIMER_AUTO_RELOAD_EN
        check("c3_running_after", running, 1'b0);
`endif

        // Multi-digit borrow and a full 100-tick run.
        do_load(16'h0100);
        do_start();
        do_tick();
        check("c100_borrow", q, 16'h0099);
        done_cnt = 0;
        for (int i = 0; i < 99; i++) begin
            do_tick();
            if (done) done_cnt++;
        end
        check("c100_done_cnt", done_cnt, 1);

        // Rejected preset while running.
        do_load(16'h0042);
        do_start();
        do_load(16'h00A5);
        check("bad_load_err", load_err, 1'b1);
        check("bad_load_q", q, 16'h0042);
        check("bad_load_state", running, 1'b1);
        do_idle();
        check("bad_load_pulse", load_err, 1'b0);

        // Pause beats tick in the same cycle.
        do_load(16'h0050);
        do_start();
        cycle(1, 0, '0, 1, 0, 1);
        check("pause_q", q, 16'h0050);
        check("pause_running", running, 1'b0);
        do_tick();
        check("pause_hold", q, 16'h0050);
        do_start();
        do_tick();
        check("resume_q", q, 16'h0049);

        // Start and tick together from IDLE: start only.
        do_load(16'h0007);
        cycle(1, 0, '0, 0, 1, 1);
        check("start_tick_q", q, 16'h0007);
        check("start_tick_run", running, 1'b1);

        // Reset mid-count, then start with a zero count.
        do_load(16'h1235);
        do_start();
        do_tick();
        check("mid_q", q, 16'h1234);
        do_reset();
        check("mid_rst_q", q, 16'h0000);
        check("mid_rst_running", running, 1'b0);
        do_start();
        check("zero_start", running, 1'b0);

`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
        do_load(16'h0002);
        do_start();
        for (int i = 1; i <= 6; i++) begin
            do_tick();
            check("reload_done", done, (i % 2 == 0));
            if (i % 2 == 0) check("reload_q", q, 16'h0002);
        end
        check("reload_running", running, 1'b1);
`endif

        // Randomized strobes against the model.
        for (int i = 0; i < 4000; i++) begin
            bit           rn, ld, pa, sa, tk;
            logic [W-1:0] lv;
            rn = ($urandom_range(0, 999) >= 4);
            ld = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 3) == 0) lv = W'($urandom);
            else                           lv = to_bcd($urandom_range(1, 25));
            pa = ($urandom_range(0, 99) < 3);
            sa = ($urandom_range(0, 99) < 10);
            tk = ($urandom_range(0, 99) < 60);
            cycle(rn, ld, lv, pa, sa, tk);
            for (int d = 0; d < ND; d++) begin
                logic [W-1:0] qv;
                qv = q;
                if (qv[d*4 +: 4] > 4'd9) check("nibble_range", qv[d*4 +: 4], 4'd9);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
